// File: rtl/forwarding_hazard_unit_pkg.sv
// rtl/forwarding_hazard_unit_pkg.sv - shared types for the EX forwarding/hazard unit
package forwarding_hazard_unit_pkg;

    localparam int REG_AW = 5;
    localparam int FWD_W  = 2;

    typedef enum logic [FWD_W-1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic              is_load;
        logic [REG_AW-1:0] rd;
    } shadow_slot_t;

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// rtl/forwarding_hazard_unit_if.sv - ID-side decode info in, forwarding/hazard controls out
interface forwarding_hazard_unit_if
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_we;
    logic              id_is_load;
    logic              mem_stall;
    logic              ex_br_taken;
    logic [FWD_W-1:0]  ex_fwd_sel1;
    logic [FWD_W-1:0]  ex_fwd_sel2;
    logic              id_hold;
    logic              ex_bubble;
    logic              id_wb_byp1;
    logic              id_wb_byp2;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
        output mem_stall, ex_br_taken,
        input  ex_fwd_sel1, ex_fwd_sel2, id_hold, ex_bubble, id_wb_byp1, id_wb_byp2, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
        input  mem_stall, ex_br_taken,
        output ex_fwd_sel1, ex_fwd_sel2, id_hold, ex_bubble, id_wb_byp1, id_wb_byp2, stall_cnt
    );
endinterface

// File: rtl/forwarding_hazard_unit_fwd_hit_cmp.sv
// rtl/forwarding_hazard_unit_fwd_hit_cmp.sv - does a shadow slot produce the register an operand reads
module fwd_hit_cmp
    import forwarding_hazard_unit_pkg::*;
(
    input  shadow_slot_t      slot,
    input  logic [REG_AW-1:0] addr,
    input  logic              use_flag,
    output logic              hit
);
    // Load-ness only matters to the stall decision, which the top makes on the EX slot itself.
    logic unused_is_load;
    assign unused_is_load = slot.is_load;

    // x0 is hardwired zero: never a forwarding source.
    assign hit = use_flag && slot.valid && slot.we && (slot.rd == addr) && (addr != '0);
endmodule

// File: rtl/forwarding_hazard_unit.sv
// rtl/forwarding_hazard_unit.sv - tracks in-flight destinations, drives EX forwarding selects and stalls
module forwarding_hazard_unit
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  logic                     clk,
    input  logic                     rst,
    forwarding_hazard_unit_if.slave  bus
);
    shadow_slot_t     ex_s, mem_s, wb_s;
    fwd_sel_t         sel1_q, sel2_q, sel1_d, sel2_d;
    logic             bubble_q;
    logic [CNT_W-1:0] cnt_q;

    logic hit_ex1, hit_ex2, hit_mem1, hit_mem2, hit_wb1, hit_wb2;
    logic load_use;

    fwd_hit_cmp u_ex1  (.slot(ex_s),  .addr(bus.id_rs1), .use_flag(bus.id_use_rs1), .hit(hit_ex1));
    fwd_hit_cmp u_ex2  (.slot(ex_s),  .addr(bus.id_rs2), .use_flag(bus.id_use_rs2), .hit(hit_ex2));
    fwd_hit_cmp u_mem1 (.slot(mem_s), .addr(bus.id_rs1), .use_flag(bus.id_use_rs1), .hit(hit_mem1));
    fwd_hit_cmp u_mem2 (.slot(mem_s), .addr(bus.id_rs2), .use_flag(bus.id_use_rs2), .hit(hit_mem2));
    fwd_hit_cmp u_wb1  (.slot(wb_s),  .addr(bus.id_rs1), .use_flag(bus.id_use_rs1), .hit(hit_wb1));
    fwd_hit_cmp u_wb2  (.slot(wb_s),  .addr(bus.id_rs2), .use_flag(bus.id_use_rs2), .hit(hit_wb2));

    assign load_use = bus.id_valid && ex_s.is_load && (hit_ex1 || hit_ex2);

    // Whoever sits in EX now will be in MEM when this ID instruction reaches EX; nearer producer wins.
    always_comb begin
        sel1_d = FWD_NONE;
        sel2_d = FWD_NONE;
        if (hit_ex1)       sel1_d = FWD_MEM;
        else if (hit_mem1) sel1_d = FWD_WB;
        if (hit_ex2)       sel2_d = FWD_MEM;
        else if (hit_mem2) sel2_d = FWD_WB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_s     <= '0;
            mem_s    <= '0;
            wb_s     <= '0;
            sel1_q   <= FWD_NONE;
            sel2_q   <= FWD_NONE;
            bubble_q <= 1'b0;
            cnt_q    <= '0;
        end else if (!bus.mem_stall) begin
            wb_s  <= mem_s;
            mem_s <= ex_s;
            if (bus.ex_br_taken || load_use) begin
                ex_s     <= '0;
                bubble_q <= 1'b1;
                sel1_q   <= FWD_NONE;
                sel2_q   <= FWD_NONE;
                if (!bus.ex_br_taken)
                    cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                ex_s     <= '{valid: bus.id_valid, we: bus.id_we, is_load: bus.id_is_load, rd: bus.id_rd};
                bubble_q <= ~bus.id_valid;
                sel1_q   <= sel1_d;
                sel2_q   <= sel2_d;
            end
        end
    end

    assign bus.id_hold     = load_use && !bus.ex_br_taken && !bus.mem_stall;
    assign bus.id_wb_byp1  = hit_wb1;
    assign bus.id_wb_byp2  = hit_wb2;
    assign bus.ex_fwd_sel1 = sel1_q;
    assign bus.ex_fwd_sel2 = sel2_q;
    assign bus.ex_bubble   = bubble_q;
    assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb/tb_forwarding_hazard_unit.sv - directed plus randomized checks against an in-flight instruction model
module tb_forwarding_hazard_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    forwarding_hazard_unit_if #(.CNT_W(32)) bus ();
    forwarding_hazard_unit #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit       valid;
        bit       we;
        bit       ld;
        bit [4:0] rd;
    } instr_t;

    // pipe[0] is in EX, pipe[1] in MEM, pipe[2] in WB
    instr_t    pipe[$];
    bit [1:0]  m_sel1, m_sel2;
    bit        m_bub;
    bit [31:0] m_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit writes(instr_t p, bit [4:0] r);
        return p.valid && p.we && p.rd == r && r != 0;
    endfunction

    function automatic bit [1:0] fwd(bit u, bit [4:0] r);
        if (!u) return 2'b00;
        if (writes(pipe[0], r)) return 2'b10;
        if (writes(pipe[1], r)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        instr_t z;
        z = '{valid: 0, we: 0, ld: 0, rd: 0};
        pipe = {z, z, z};
        m_sel1 = 0; m_sel2 = 0; m_bub = 0; m_cnt = 0;
    endtask

    task automatic check_regs();
        check("ex_fwd_sel1", bus.ex_fwd_sel1, m_sel1);
        check("ex_fwd_sel2", bus.ex_fwd_sel2, m_sel2);
        check("ex_bubble",   bus.ex_bubble,   m_bub);
        check("stall_cnt",   bus.stall_cnt,   m_cnt);
    endtask

    // Drives one ID cycle at the negedge, checks comb outputs, clocks, then checks registered outputs.
    task automatic step(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit u1, input bit u2,
                        input bit [4:0] rd, input bit we, input bit ld, input bit br, input bit ms);
        bit lu;
        instr_t n;
        bus.id_valid = v;  bus.id_rs1 = r1; bus.id_rs2 = r2; bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
        bus.id_rd = rd;    bus.id_we = we;  bus.id_is_load = ld; bus.ex_br_taken = br; bus.mem_stall = ms;
        #1;
        lu = v && pipe[0].ld && ((u1 && writes(pipe[0], r1)) || (u2 && writes(pipe[0], r2)));
        check("id_hold",    bus.id_hold,    lu && !br && !ms);
        check("id_wb_byp1", bus.id_wb_byp1, u1 && writes(pipe[2], r1));
        check("id_wb_byp2", bus.id_wb_byp2, u2 && writes(pipe[2], r2));
        if (!ms) begin
            n = '{valid: 0, we: 0, ld: 0, rd: 0};
            if (br || lu) begin
                m_bub = 1; m_sel1 = 0; m_sel2 = 0;
                if (!br) m_cnt++;
            end else begin
                n = '{valid: v, we: we, ld: ld, rd: rd};
                m_bub = !v;
                m_sel1 = fwd(u1, r1);
                m_sel2 = fwd(u2, r2);
            end
            void'(pipe.pop_back());
            pipe.push_front(n);
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic do_reset();
        rst = 1;
        bus.id_valid = 1; bus.id_rs1 = 1; bus.id_rs2 = 1; bus.id_use_rs1 = 1; bus.id_use_rs2 = 1;
        bus.id_rd = 1; bus.id_we = 1; bus.id_is_load = 0; bus.ex_br_taken = 0; bus.mem_stall = 0;
        @(negedge clk);
        model_clear();
        check_regs();
        check("rst_hold", bus.id_hold,    0);
        check("rst_byp1", bus.id_wb_byp1, 0);
        check("rst_byp2", bus.id_wb_byp2, 0);
        rst = 0;
    endtask

    initial begin
        rst = 1;
        do_reset();

        // add x1 ; add x2,x1,x3 -> MEM forward on rs1
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(1, 1, 3, 1, 1, 2, 1, 0, 0, 0);
        check("dir_mem_fwd", bus.ex_fwd_sel1, 2'b10);
        // add x1 ; nop ; sub x4,x5,x1 -> WB forward on rs2
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 5, 1, 1, 1, 4, 1, 0, 0, 0);
        check("dir_wb_fwd", bus.ex_fwd_sel2, 2'b01);
        // add x1 ; add x1 ; use x1 -> MEM wins
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0, 9, 1, 0, 0, 0);
        check("dir_mem_wins", bus.ex_fwd_sel1, 2'b10);
        // lw x6 ; add x7,x6,x6 -> one stall, then WB forward on both
        step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        step(1, 6, 6, 1, 1, 7, 1, 0, 0, 0);
        check("dir_lu_bubble", bus.ex_bubble, 1);
        check("dir_lu_cnt",    bus.stall_cnt, 1);
        step(1, 6, 6, 1, 1, 7, 1, 0, 0, 0);
        check("dir_lu_sel1", bus.ex_fwd_sel1, 2'b01);
        check("dir_lu_sel2", bus.ex_fwd_sel2, 2'b01);
        // lw x6 ; add x7,x6 with a taken branch -> flush, no stall counted
        step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        step(1, 6, 0, 1, 0, 7, 1, 0, 1, 0);
        check("dir_br_bubble", bus.ex_bubble, 1);
        check("dir_br_cnt",    bus.stall_cnt, 1);
        // x0 producers never forward
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        check("dir_x0_sel1", bus.ex_fwd_sel1, 2'b00);
        // WB write x8 while ID reads x8
        step(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.id_rs1 = 8; bus.id_use_rs1 = 1; #1;
        check("dir_wb_byp1", bus.id_wb_byp1, 1);
        // forwarding pair with mem_stall held three cycles
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step(1, 3, 0, 1, 0, 4, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 4, 3, 1, 1, 5, 1, 0, 1, 1);
        check("dir_stall_frz", bus.ex_fwd_sel1, 2'b10);
        step(1, 4, 3, 1, 1, 5, 1, 0, 0, 0);
        do_reset();

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                step(bit'($urandom_range(9) != 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
                     bit'($urandom_range(1)), bit'($urandom_range(1)), 5'($urandom_range(3)),
                     bit'($urandom_range(4) != 0), bit'($urandom_range(2) == 0),
                     bit'($urandom_range(9) == 0), bit'($urandom_range(6) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
